// File: rtl/mux4_rst_reg.sv
// Registered 4:1 selector with asynchronous active-high clear; one-cycle load latency under i_en.
// Optional registered even-parity output o_par when MUX4_RST_PARITY_EN is defined.
module mux4_rst_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_con,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_a,
  output logic [1:0]       o_sel,
  output logic             o_valid
`ifdef MUX4_RST_PARITY_EN
  ,
  output logic             o_par
`endif
);

  logic [WIDTH-1:0] sel_dat;
  logic [WIDTH-1:0] a_d, a_q;
  logic [1:0]       sel_d, sel_q;
  logic             valid_d, valid_q;

  always_comb begin
    sel_dat = i_a;
    case (i_con)
      2'd0: sel_dat = i_a;
      2'd1: sel_dat = i_b;
      2'd2: sel_dat = i_c;
      2'd3: sel_dat = i_d;
    endcase
  end

  // Hold on i_en=0; valid is sticky until the next reset.
  always_comb begin
    a_d     = a_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (i_en) begin
      a_d     = sel_dat;
      sel_d   = i_con;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      a_q     <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign o_a     = a_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;

`ifdef MUX4_RST_PARITY_EN
  logic par_d, par_q;

  assign par_d = i_en ? ^sel_dat : par_q;

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign o_par = par_q;
`endif

endmodule

// File: tb/tb_mux4_rst_reg.sv
// Scoreboard bench for mux4_rst_reg: directed scenarios then randomized cycles against a reference model.
module tb_mux4_rst_reg;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [1:0]   sel;
    logic         vld;
    logic         par;
  } exp_t;

  logic         clk = 1'b0;
  logic         rs  = 1'b1;
  logic [W-1:0] i_a = '0, i_b = '0, i_c = '0, i_d = '0;
  logic [1:0]   i_con = 2'd0;
  logic         i_en = 1'b0;
  logic [W-1:0] o_a;
  logic [1:0]   o_sel;
  logic         o_valid;
`ifdef MUX4_RST_PARITY_EN
  logic         o_par;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  exp_t ref_st;

  mux4_rst_reg #(.WIDTH(W)) dut (
    .clk(clk), .rs(rs),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
    .i_con(i_con), .i_en(i_en),
    .o_a(o_a), .o_sel(o_sel), .o_valid(o_valid)
`ifdef MUX4_RST_PARITY_EN
    , .o_par(o_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".o_a"}, 32'(o_a), 32'(e.a));
    chk({tag, ".o_sel"}, 32'(o_sel), 32'(e.sel));
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(e.vld));
`ifdef MUX4_RST_PARITY_EN
    chk({tag, ".o_par"}, 32'(o_par), 32'(e.par));
`endif
  endtask

  // Reference: the register contents after an edge, derived from reset/enable rules.
  function automatic void model_step(input logic r, input logic en, input logic [1:0] con,
                                     input logic [W-1:0] d0, input logic [W-1:0] d1,
                                     input logic [W-1:0] d2, input logic [W-1:0] d3);
    logic [W-1:0] data [4];
    data[0] = d0; data[1] = d1; data[2] = d2; data[3] = d3;
    if (r) begin
      ref_st = '{a: '0, sel: 2'd0, vld: 1'b0, par: 1'b0};
    end else if (en) begin
      ref_st.a   = data[con];
      ref_st.sel = con;
      ref_st.vld = 1'b1;
      ref_st.par = ^data[con];
    end
  endfunction

  task automatic cycle(input logic r, input logic en, input logic [1:0] con,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    @(negedge clk);
    rs = r; i_en = en; i_con = con;
    i_a = d0; i_b = d1; i_c = d2; i_d = d3;
    model_step(r, en, con, d0, d1, d2, d3);
    sb_q.push_back(ref_st);
  endtask

  // Assert reset between edges and confirm the clear without any clock edge.
  task automatic async_rst();
    exp_t z;
    @(negedge clk);
    rs = 1'b1;
    #1;
    z = '{a: '0, sel: 2'd0, vld: 1'b0, par: 1'b0};
    chk_state("async_rst", z);
    model_step(1'b1, i_en, i_con, i_a, i_b, i_c, i_d);
    sb_q.push_back(ref_st);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk_state("edge", e);
    end
  end

  initial begin
    exp_t z;
    ref_st = '{a: '0, sel: 2'd0, vld: 1'b0, par: 1'b0};
    #3;
    z = ref_st;
    chk_state("reset", z);

    cycle(1'b1, 1'b1, 2'd3, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd1, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd0, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd3, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd2, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd0, 8'd1, 8'd0, 8'd0, 8'd1);
    async_rst();
    repeat (3) cycle(1'b1, 1'b1, 2'd3, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd3, 8'd1, 8'd0, 8'd0, 8'd1);
    repeat (3) cycle(1'b0, 1'b0, 2'd1, 8'd1, 8'd0, 8'd0, 8'd1);
    cycle(1'b0, 1'b1, 2'd2, 8'd0, 8'd0, 8'h07, 8'd0);
    cycle(1'b0, 1'b1, 2'd0, 8'h03, 8'd0, 8'h07, 8'd0);
    // Reset during an enabled edge must win over the load.
    cycle(1'b1, 1'b1, 2'd2, 8'hA5, 8'h5A, 8'hFF, 8'h11);
    cycle(1'b0, 1'b1, 2'd2, 8'hA5, 8'h5A, 8'hFF, 8'h11);

    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 31) == 0) async_rst();
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
